hamming_enc_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 7-bit-to-11-bit hamming encoder instance among NREQ requesters. It accepts one 7-bit data word per grant and drives it onto the encoder input. It waits out the encoder's one-cycle registered latency, captures the 11-bit codeword, and presents it with the requester ID on a valid/ready output port. It sits between the data sources and the shared encoder on the transmit path.

---
 rtl/hamming_enc_arbiter.sv | 93 +++++++++
 tb/tb_hamming_enc_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hamming_enc_arbiter.sv
// rtl/hamming_enc_arbiter.sv - round-robin sequencer sharing one registered 7->11 hamming encoder
module hamming_enc_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int CNTW = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [7*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic [6:0]        enc_x,
   input  logic [10:0]       enc_z,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [10:0]       out_code,
   output logic [IDW-1:0]    out_id,
   output logic              busy,
   output logic [CNTW-1:0]   word_count
);

   typedef enum logic [1:0] {IDLE, ENC, CAP, OUT} state_t;

   state_t          state;
   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  winner;
   logic [IDW-1:0]  next_ptr;
   logic [NREQ-1:0] upper;
   logic [NREQ-1:0] upper_req;
   logic            found;
   logic [6:0]      win_data;

   function automatic logic [IDW-1:0] lowest(input logic [NREQ-1:0] v);
      logic [IDW-1:0] ii;
      lowest = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         ii = IDW'(i);
         if (v[ii]) lowest = ii;
      end
   endfunction

   // Requests at or above rr_ptr win first; otherwise wrap to the lowest index.
   always_comb begin
      upper = '0;
      for (int i = 0; i < NREQ; i++) upper[IDW'(i)] = (IDW'(i) >= rr_ptr);
      upper_req = req_valid & upper;
      found     = |req_valid;
      winner    = (|upper_req) ? lowest(upper_req) : lowest(req_valid);
      next_ptr  = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
      win_data  = '0;
      for (int i = 0; i < NREQ; i++)
         if (IDW'(i) == winner) win_data = req_data[7*i +: 7];
   end

   assign req_ready = (state == IDLE && !rst && found) ? (NREQ'(1) << winner) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         enc_x      <= '0;
         out_valid  <= 1'b0;
         out_code   <= '0;
         out_id     <= '0;
         busy       <= 1'b0;
         word_count <= '0;
      end else begin
         case (state)
            IDLE: if (found) begin
               enc_x  <= win_data;
               out_id <= winner;
               rr_ptr <= next_ptr;
               busy   <= 1'b1;
               state  <= ENC;
            end
            ENC: state <= CAP;
            CAP: begin
               out_code  <= enc_z;
               out_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: if (out_ready) begin
               out_valid  <= 1'b0;
               busy       <= 1'b0;
               word_count <= word_count + CNTW'(1);
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hamming_enc_arbiter.sv
// tb/tb_hamming_enc_arbiter.sv - scoreboard bench with behavioural arbiter/encoder model
module tb_hamming_enc_arbiter;
   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int CNTW = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   req_valid = '0;
   logic [7*NREQ-1:0] req_data = '0;
   logic [NREQ-1:0]   req_ready;
   logic [6:0]        enc_x;
   logic [10:0]       enc_z;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [10:0]       out_code;
   logic [IDW-1:0]    out_id;
   logic              busy;
   logic [CNTW-1:0]   word_count;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: phase counts cycles since grant (0 idle, 1..2 in flight, 3 presenting)
   int         m_phase = 0;
   int         m_rr    = 0;
   int         m_count = 0;
   logic [6:0] m_encx  = '0;
   logic [IDW+10:0] sb_q[$];
   event sample_ev;

   hamming_enc_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .enc_x(enc_x), .enc_z(enc_z), .out_valid(out_valid),
      .out_ready(out_ready), .out_code(out_code), .out_id(out_id), .busy(busy),
      .word_count(word_count)
   );

   always #5 clk = ~clk;

   function automatic logic [10:0] ham(input logic [6:0] d);
      int pos [7];
      logic [11:0] z;
      pos = '{3, 5, 6, 7, 9, 10, 11};
      z = '0;
      for (int j = 0; j < 7; j++) z[pos[j]] = d[j];
      for (int p = 1; p <= 8; p = p * 2)
         for (int q = 1; q <= 11; q++)
            if ((q & p) != 0 && q != p) z[p] = z[p] ^ z[q];
      return z[11:1];
   endfunction

   // Shared encoder with one cycle of registered latency
   always @(posedge clk) enc_z <= ham(enc_x);

   function automatic int model_winner(input logic [NREQ-1:0] v);
      for (int k = 0; k < NREQ; k++)
         if (v[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
      return -1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic [NREQ-1:0] v,
                       input logic [7*NREQ-1:0] d, input logic rdy);
      int w;
      logic [NREQ-1:0] exp_rdy;
      logic [6:0] wd;
      @(negedge clk);
      rst = r; req_valid = v; req_data = d; out_ready = rdy;
      #1;
      w = model_winner(v);
      exp_rdy = (!r && m_phase == 0 && w >= 0) ? NREQ'(1) << w : '0;
      chk("req_ready", req_ready, exp_rdy);
      chk("busy", busy, m_phase != 0);
      chk("out_valid", out_valid, m_phase == 3);
      chk("enc_x", enc_x, m_encx);
      chk("word_count", word_count, m_count);
      -> sample_ev;
      if (r) begin
         m_phase = 0; m_rr = 0; m_count = 0; m_encx = '0;
         sb_q.delete();
      end else if (m_phase == 0) begin
         if (w >= 0) begin
            wd = 7'((d >> (7 * w)) & 28'h7F);
            sb_q.push_back({IDW'(w), ham(wd)});
            m_encx  = wd;
            m_rr    = (w + 1) % NREQ;
            m_phase = 1;
         end
      end else if (m_phase < 3) begin
         m_phase++;
      end else if (rdy) begin
         m_count = (m_count + 1) % (1 << CNTW);
         m_phase = 0;
      end
   endtask

   task automatic txn(input int id, input logic [6:0] data);
      logic [7*NREQ-1:0] d;
      d = '0;
      d[7*id +: 7] = data;
      step(1'b0, NREQ'(1) << id, d, 1'b1);
      repeat (3) step(1'b0, '0, '0, 1'b1);
   endtask

   initial begin
      forever begin
         @(sample_ev);
         if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               logic [IDW+10:0] e;
               e = sb_q.pop_front();
               chk("out_code", out_code, e[10:0]);
               chk("out_id", out_id, e[IDW+10:11]);
            end
         end
      end
   end

   initial begin
      logic [7*NREQ-1:0] d;
      int order [5];
      int g, last;
      order = '{0, 1, 2, 3, 0};

      repeat (2) step(1'b1, '0, '0, 1'b0);
      chk("reset_out_code", out_code, 0);
      chk("reset_out_id", out_id, 0);

      // Single requester, 0x55
      d = '0; d[6:0] = 7'h55;
      step(1'b0, 4'b0001, d, 1'b1);
      repeat (3) step(1'b0, '0, '0, 1'b1);
      chk("code_55", out_code, 11'h52F);
      step(1'b0, '0, '0, 1'b1);
      chk("count_after_one", word_count, 1);

      // All four requesting continuously
      step(1'b1, '0, '0, 1'b0);
      d = {7'h00, 7'h55, 7'h7F, 7'h00};
      g = 0; last = 0;
      for (int c = 0; c < 20; c++) begin
         step(1'b0, 4'b1111, d, 1'b1);
         if (req_ready != 0 && g < 5) begin
            chk("grant_order", req_ready, 4'b0001 << order[g]);
            if (g > 0) chk("grant_gap", c - last, 4);
            last = c;
            g++;
         end
      end
      chk("grant_count", g, 5);

      // Downstream stall
      step(1'b1, '0, '0, 1'b0);
      d = '0; d[20:14] = 7'h7F;
      step(1'b0, 4'b0100, d, 1'b0);
      repeat (2) step(1'b0, '0, '0, 1'b0);
      for (int c = 0; c < 10; c++) begin
         step(1'b0, 4'b1111, '0, 1'b0);
         chk("stall_code", out_code, 11'h7FF);
         chk("stall_id", out_id, 2);
      end
      step(1'b0, '0, '0, 1'b1);
      step(1'b0, '0, '0, 1'b0);
      chk("stall_idle", busy, 0);

      // Round-robin wrap with rr_ptr=2
      step(1'b1, '0, '0, 1'b0);
      txn(1, 7'h12);
      step(1'b0, 4'b0011, {7'h0, 7'h0, 7'h33, 7'h44}, 1'b1);
      chk("rr_wrap_first", req_ready, 4'b0001);
      repeat (3) step(1'b0, 4'b0011, {7'h0, 7'h0, 7'h33, 7'h44}, 1'b1);
      step(1'b0, 4'b0011, {7'h0, 7'h0, 7'h33, 7'h44}, 1'b1);
      chk("rr_wrap_second", req_ready, 4'b0010);
      repeat (3) step(1'b0, '0, '0, 1'b1);

      // Reset while in CAP
      step(1'b1, '0, '0, 1'b0);
      step(1'b0, 4'b0001, 28'h7F, 1'b1);
      step(1'b0, '0, '0, 1'b1);
      step(1'b1, '0, '0, 1'b1);
      step(1'b0, '0, '0, 1'b1);
      chk("rst_cap_encx", enc_x, 0);
      chk("rst_cap_valid", out_valid, 0);
      repeat (3) step(1'b0, '0, '0, 1'b1);

      // word_count wrap
      step(1'b1, '0, '0, 1'b0);
      for (int t = 0; t < 15; t++) txn(t % NREQ, 7'($urandom));
      step(1'b0, '0, '0, 1'b1);
      chk("count_max", word_count, 15);
      txn(0, 7'h01);
      step(1'b0, '0, '0, 1'b1);
      chk("count_wrap", word_count, 0);

      // Randomised traffic
      for (int c = 0; c < 800; c++)
         step($urandom_range(0, 99) == 0, NREQ'($urandom), 28'($urandom),
              $urandom_range(0, 3) != 0);

      step(1'b1, '0, '0, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
